// File: rtl/matrix_fb.sv
// Double-buffered pixel frame buffer sitting in front of the HUB75 driver.
// The host writes pixels (or requests a full clear) into the back buffer. The
// driver reads top/bottom pixel pairs from the front buffer. The buffers swap
// only on a driver frame boundary, so a frame is never shown half-updated.
//
// Clear FSM
//   state    | meaning
//   ST_IDLE  | host writes accepted, no fill running
//   ST_CLEAR | filling both halves of back buffer with latched colour
module matrix_fb #(
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [COL_BITS-1:0] wr_x,
  input  logic [ROW_BITS:0]   wr_y,
  input  logic [2:0]          wr_rgb,
  output logic                wr_ready,
  input  logic                clr_req,
  input  logic [2:0]          clr_rgb,
  output logic                busy,
  input  logic                swap_req,
  output logic                swap_pending,
  output logic                swap_ack,
  input  logic                frame_end,
  input  logic                rd_en,
  input  logic [ROW_BITS-1:0] rd_row,
  input  logic [COL_BITS-1:0] rd_col,
  output logic [2:0]          rd_top,
  output logic [2:0]          rd_bot
);

  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int DEPTH     = 1 << ADDR_BITS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic [2:0]           clr_rgb_q;
  logic                 front_sel;
  logic                 back_sel;
  logic                 swap_pending_q;
  logic                 swap_ack_q;
  logic                 swap_fire;
  logic                 host_wr;
  logic                 clr_wr;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;

  // Index [buffer][address]; no reset, contents are only defined once written.
  logic [2:0] mem_top [0:1][0:DEPTH-1];
  logic [2:0] mem_bot [0:1][0:DEPTH-1];

  assign busy         = (state_q == ST_CLEAR);
  assign wr_ready     = ~busy;
  assign back_sel     = ~front_sel;
  assign swap_pending = swap_pending_q;
  assign swap_ack     = swap_ack_q;

  assign wr_addr = {wr_y[ROW_BITS-1:0], wr_x};
  assign rd_addr = {rd_row, rd_col};

  // A clear in flight blocks the swap so the driver never sees a partial fill.
  assign swap_fire = frame_end & (swap_pending_q | swap_req) & ~busy;

  // Writes are suppressed while reset is held so a reset edge leaves memory alone.
  assign host_wr = rst & wr_en & ~busy;
  assign clr_wr  = rst & busy;

  // Clear FSM state register, fill counter and latched fill colour.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      clr_rgb_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (state_q == ST_IDLE && clr_req) begin
        clr_rgb_q <= clr_rgb;
      end
    end
  end

  // Clear FSM next state: walk every address once, then return to idle.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
        if (clr_cnt_q == {ADDR_BITS{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Swap control: sticky request, toggle front on an eligible frame boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      front_sel      <= 1'b0;
      swap_pending_q <= 1'b0;
      swap_ack_q     <= 1'b0;
    end else begin
      swap_ack_q <= swap_fire;
      if (swap_fire) begin
        front_sel      <= ~front_sel;
        swap_pending_q <= 1'b0;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end
    end
  end

  // Back-buffer writes; host and clear writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (host_wr) begin
      if (wr_y[ROW_BITS]) begin
        mem_bot[back_sel][wr_addr] <= wr_rgb;
      end else begin
        mem_top[back_sel][wr_addr] <= wr_rgb;
      end
    end
    if (clr_wr) begin
      mem_top[back_sel][clr_cnt_q] <= clr_rgb_q;
      mem_bot[back_sel][clr_cnt_q] <= clr_rgb_q;
    end
  end

  // Front-buffer read port, one cycle latency, holds when not strobed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_top <= 3'b000;
      rd_bot <= 3'b000;
    end else if (rd_en) begin
      rd_top <= mem_top[front_sel][rd_addr];
      rd_bot <= mem_bot[front_sel][rd_addr];
    end
  end

endmodule

// File: doc/matrix_fb.md
Name: matrix_fb

Overview:
- Double-buffered pixel frame buffer feeding the HUB75 matrix driver; sits directly upstream of matrixdrv.
- Host side writes single pixels and requests a clear into the back buffer.
- Driver side reads one top/bottom pixel pair per column from the front buffer.
- Buffers swap only at a driver frame boundary, so there is no tearing.

Parameters:
- COL_BITS, 5, column address width (32 columns).
- ROW_BITS, 4, row-pair address width (16 row pairs, 32 physical rows).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- wr_en  in  1  host pixel write strobe
- wr_x  in  COL_BITS  write column
- wr_y  in  ROW_BITS+1  write row; MSB selects the bottom half
- wr_rgb  in  3  pixel {r,g,b}
- wr_ready  out  1  high when writes are accepted (not busy)
- clr_req  in  1  pulse: fill back buffer with clr_rgb
- clr_rgb  in  3  fill colour, sampled on accepted clr_req
- busy  out  1  clear in progress
- swap_req  in  1  pulse: request buffer swap
- swap_pending  out  1  swap requested, not yet done
- swap_ack  out  1  one-cycle pulse when swap is done
- frame_end  in  1  pulse from driver after last row of a frame
- rd_en  in  1  driver read strobe
- rd_row  in  ROW_BITS  row pair
- rd_col  in  COL_BITS  column
- rd_top  out  3  top-half pixel {r,g,b}
- rd_bot  out  3  bottom-half pixel {r,g,b}

Behaviour:
- Storage:
  - Two buffers × two halves; each half is 2^(ROW_BITS+COL_BITS) × 3 bits (512 × 3 by default).
  - Address = {row, col}.
  - Registered front_sel picks the front buffer; back buffer = !front_sel.
  - Memory contents are not reset.
- Reset (rst=0 at a clk edge): front_sel=0, state=IDLE, busy=0, wr_ready=1, swap_pending=0, swap_ack=0, rd_top=0, rd_bot=0, clear counter=0.
- Write:
  - When wr_en && !busy, write wr_rgb to the back buffer half wr_y[ROW_BITS] at {wr_y[ROW_BITS-1:0], wr_x} on that edge.
  - wr_en while busy is dropped silently.
  - wr_ready = !busy, combinational from state.
- Read:
  - When rd_en, rd_top/rd_bot take front-buffer data at {rd_row, rd_col} on the next edge (latency 1).
  - When rd_en=0, the outputs hold.
  - Reads are never blocked by busy or a clear.
- Clear FSM (IDLE, CLEAR):
  - IDLE→CLEAR on clr_req: latch clr_rgb, counter=0, busy=1 from the next cycle.
  - In CLEAR, each cycle writes the latched colour to both halves of the back buffer at the counter address, then increments.
  - Counter at max (511) → write, then IDLE, busy=0.
  - Busy lasts exactly 512 cycles.
  - clr_req while in CLEAR is ignored.
  - clr_req and wr_en in the same IDLE cycle: the write completes and the clear starts next cycle, overwriting it.
- Swap:
  - swap_req sets swap_pending (sticky); repeat requests are no-ops.
  - Swap fires on a frame_end cycle when (swap_pending || swap_req) && !busy. On the next edge: front_sel toggles, swap_pending=0, swap_ack=1 for one cycle.
  - frame_end while busy defers the swap to a later frame_end; pending stays set.
  - frame_end without a request does nothing.
  - A read issued in the swap cycle uses the old front_sel.
  - A write issued in the swap cycle goes to the old back buffer, which becomes front. The host must wait for swap_ack before writing.
- Reset mid-clear or mid-pending: state returns to IDLE, the pending request is lost, and back buffer contents are undefined.

Test Plan:
1. Reset, no swap. Write (x=3, y=2, rgb=5) and (x=3, y=18, rgb=2), pulse swap_req then frame_end, read row=2 col=3 → rd_top=5, rd_bot=2 one cycle after rd_en; swap_ack high exactly one cycle.
2. Write rgb=7 at (0,0) with no swap; read (0,0) → front still returns the pre-write value; swap_req alone without frame_end → swap_pending=1, front_sel unchanged for 100 cycles.
3. clr_req with clr_rgb=3 → busy=1 for exactly 512 cycles; wr_en during busy is dropped. After swap, reads at (0,0), (15,31) and (7,17) → top=bot=3.
4. swap_req then frame_end while busy (mid-clear) → no swap_ack. Second frame_end after busy falls → swap_ack, swap_pending=0.
5. swap_req and frame_end in the same cycle with pending=0 → swap_ack next cycle; rd_en in that same cycle returns old-front data.
6. Assert rst=0 at cycle 100 of a clear with swap pending → next cycle busy=0, swap_pending=0, wr_ready=1, rd_top=rd_bot=0.
